// File: rtl/byte4_sched_pkg.sv
// Shared types and constants for the byte4 read-port scheduler.
package byte4_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_SHIFT = 2'd1,
        CMD_DATA  = 2'd2
    } cmd_e;

    localparam int SHIFT_BYTES = 1;
    localparam int DATA_BYTES  = 4;

endpackage

// File: rtl/byte4_arb.sv
// Two-way arbiter: data wins by default, shift is forced through after
// STARVE_MAX consecutive losses so the match finder cannot be locked out.
module byte4_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic shift_req_i,
    input  logic data_req_i,
    output logic shift_gnt_o,
    output logic data_gnt_o
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          starved;

    assign starved = (starve_q == CW'(STARVE_MAX));

    always_comb begin
        shift_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        if (en_i) begin
            if (shift_req_i && (starved || !data_req_i)) begin
                shift_gnt_o = 1'b1;
            end else if (data_req_i) begin
                data_gnt_o = 1'b1;
            end
        end
    end

    // Counter only moves on an actual loss; it holds while nothing is issued.
    always_comb begin
        starve_d = starve_q;
        if (!shift_req_i || shift_gnt_o) begin
            starve_d = '0;
        end else if (data_gnt_o && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/byte4_sched.sv
// Sequencer in front of byte_addressing: arbitrates shift/data requests,
// keeps one command outstanding, tracks block bytes and flags errors.
//
//   state | meaning
//   IDLE  | after reset, waiting for blk_start
//   RUN   | block active, no command outstanding, may issue
//   WAIT  | one command outstanding, waiting for its valid or timeout
//   DONE  | block finished or timed out, waiting for blk_start
module byte4_sched
    import byte4_sched_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TMO_CYC    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              blk_start_i,
    input  logic [ADDR_W-1:0] blk_len_i,
    input  logic              shift_req_i,
    output logic              shift_gnt_o,
    output logic              shift_ack_o,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    output logic              data_ack_o,
    output logic              rd_shift_en_o,
    output logic              rd_data_en_o,
    input  logic              byte4_busy_i,
    input  logic              byte4_svalid_i,
    input  logic              byte4_dvalid_i,
    input  logic [ADDR_W-1:0] abs_addr_i,
    output logic [ADDR_W-1:0] bytes_left_o,
    output logic              blk_done_o,
    output logic              timeout_err_o,
    output logic              addr_err_o
);
    localparam int TW = $clog2(TMO_CYC + 1);

    state_e            state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [ADDR_W-1:0] left_q, left_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              terr_q, terr_d;
    logic              aerr_q, aerr_d;
    logic              done_q, done_d;
    logic              sack_q, sack_d;
    logic              dack_q, dack_d;

    logic              issue_ok;
    logic              data_elig;
    logic              arb_sgnt;
    logic              arb_dgnt;
    logic              resp;
    logic [ADDR_W-1:0] step_bytes;

    assign issue_ok  = (state_q == ST_RUN) && !byte4_busy_i && (left_q != '0);
    // A data read near the end of a block would overrun it, so data waits.
    assign data_elig = data_req_i && (left_q >= ADDR_W'(DATA_BYTES));

    byte4_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (issue_ok),
        .shift_req_i (shift_req_i),
        .data_req_i  (data_elig),
        .shift_gnt_o (arb_sgnt),
        .data_gnt_o  (arb_dgnt)
    );

    assign resp = (state_q == ST_WAIT) &&
                  (((cmd_q == CMD_SHIFT) && byte4_svalid_i) ||
                   ((cmd_q == CMD_DATA)  && byte4_dvalid_i));

    assign step_bytes = (cmd_q == CMD_DATA) ? ADDR_W'(DATA_BYTES) : ADDR_W'(SHIFT_BYTES);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NONE;
            left_q     <= '0;
            exp_addr_q <= '0;
            tmo_q      <= '0;
            terr_q     <= 1'b0;
            aerr_q     <= 1'b0;
            done_q     <= 1'b0;
            sack_q     <= 1'b0;
            dack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            left_q     <= left_d;
            exp_addr_q <= exp_addr_d;
            tmo_q      <= tmo_d;
            terr_q     <= terr_d;
            aerr_q     <= aerr_d;
            done_q     <= done_d;
            sack_q     <= sack_d;
            dack_q     <= dack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        left_d     = left_q;
        exp_addr_d = exp_addr_q;
        tmo_d      = tmo_q;
        terr_d     = terr_q;
        aerr_d     = aerr_q;
        done_d     = 1'b0;
        sack_d     = 1'b0;
        dack_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (blk_start_i) begin
                    state_d    = ST_RUN;
                    cmd_d      = CMD_NONE;
                    left_d     = blk_len_i;
                    exp_addr_d = abs_addr_i;
                    tmo_d      = '0;
                    terr_d     = 1'b0;
                    aerr_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (arb_sgnt) begin
                    cmd_d   = CMD_SHIFT;
                    state_d = ST_WAIT;
                    tmo_d   = TW'(1);
                end else if (arb_dgnt) begin
                    cmd_d   = CMD_DATA;
                    state_d = ST_WAIT;
                    tmo_d   = TW'(1);
                end
            end
            ST_WAIT: begin
                // A response in the expiry cycle still counts: it is checked first.
                if (resp) begin
                    sack_d     = (cmd_q == CMD_SHIFT);
                    dack_d     = (cmd_q == CMD_DATA);
                    aerr_d     = aerr_q || (abs_addr_i != exp_addr_q);
                    left_d     = left_q - step_bytes;
                    exp_addr_d = exp_addr_q + step_bytes;
                    cmd_d      = CMD_NONE;
                    tmo_d      = '0;
                    if (left_q == step_bytes) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (tmo_q == TW'(TMO_CYC - 1)) begin
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                    cmd_d   = CMD_NONE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        shift_gnt_o   = arb_sgnt;
        data_gnt_o    = arb_dgnt;
        rd_shift_en_o = arb_sgnt;
        rd_data_en_o  = arb_dgnt;
        shift_ack_o   = sack_q;
        data_ack_o    = dack_q;
        bytes_left_o  = left_q;
        blk_done_o    = done_q;
        timeout_err_o = terr_q;
        addr_err_o    = aerr_q;
    end

endmodule

// File: tb/tb_byte4_sched.sv
// Bench for byte4_sched: a byte_addressing responder model plus a queue of
// expected grants derived from the arbitration rules.
module tb_byte4_sched;
    localparam int AW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 64;

    logic          clk = 1'b0;
    logic          rst, blk_start, shift_req, data_req, busy, svalid, dvalid;
    logic [AW-1:0] blk_len, abs_addr, bytes_left;
    logic          shift_gnt, shift_ack, data_gnt, data_ack;
    logic          rd_shift_en, rd_data_en, blk_done, timeout_err, addr_err;

    always #5 clk = ~clk;

    byte4_sched #(.ADDR_W(AW), .STARVE_MAX(SMAX), .TMO_CYC(TMO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .blk_start_i    (blk_start),
        .blk_len_i      (blk_len),
        .shift_req_i    (shift_req),
        .shift_gnt_o    (shift_gnt),
        .shift_ack_o    (shift_ack),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_ack_o     (data_ack),
        .rd_shift_en_o  (rd_shift_en),
        .rd_data_en_o   (rd_data_en),
        .byte4_busy_i   (busy),
        .byte4_svalid_i (svalid),
        .byte4_dvalid_i (dvalid),
        .abs_addr_i     (abs_addr),
        .bytes_left_o   (bytes_left),
        .blk_done_o     (blk_done),
        .timeout_err_o  (timeout_err),
        .addr_err_o     (addr_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int exp_q[$];          // expected grants: 1 = shift, 2 = data
    int m_left, m_starve;

    logic          n_start, n_sreq, n_dreq, n_busy;
    logic [AW-1:0] n_len;

    bit            resp_en;
    int            resp_dly, fault_at, pend_kind, pend_cnt, resp_idx;
    logic [AW-1:0] m_addr;

    logic [AW-1:0] e_left, e_left_n, ld_val;
    bit            e_sack, e_sack_n, e_dack, e_dack_n, e_done, e_done_n, e_aerr, e_aerr_n, ld_pend;
    int            n_gnt, n_sgnt, n_dgnt, done_cnt;

    task automatic clear_model();
        exp_q.delete();
        m_left = 0; m_starve = 0;
        resp_en = 1'b1; resp_dly = 1; fault_at = -1;
        pend_kind = 0; pend_cnt = 0; resp_idx = 0;
        e_left = '0; e_left_n = '0; ld_val = '0; ld_pend = 1'b0;
        e_sack = 0; e_sack_n = 0; e_dack = 0; e_dack_n = 0;
        e_done = 0; e_done_n = 0; e_aerr = 0; e_aerr_n = 0;
        n_gnt = 0; n_sgnt = 0; n_dgnt = 0; done_cnt = 0;
    endtask

    // Expected grant order for the given request levels, continuing from the
    // current model state when len == 0.
    task automatic plan(input int len, input bit sreq, input bit dreq);
        bit dok;
        if (len > 0) m_left = len;
        while (m_left > 0) begin
            dok = dreq && (m_left >= 4);
            if (sreq && (!dok || m_starve == SMAX)) begin
                exp_q.push_back(1);
                m_starve = 0;
                m_left -= 1;
            end else if (dok) begin
                exp_q.push_back(2);
                if (!sreq) m_starve = 0;
                else if (m_starve < SMAX) m_starve += 1;
                m_left -= 4;
            end else begin
                if (!sreq) m_starve = 0;
                break;
            end
        end
    endtask

    task automatic step();
        int nb;
        int k;
        int ek;
        @(posedge clk); #1;
        blk_start = n_start; blk_len = n_len; shift_req = n_sreq;
        data_req = n_dreq; busy = n_busy;
        e_left = e_left_n; e_sack = e_sack_n; e_dack = e_dack_n;
        e_done = e_done_n; e_aerr = e_aerr_n;
        e_sack_n = 0; e_dack_n = 0; e_done_n = 0;
        if (ld_pend) begin
            e_left_n = ld_val; e_aerr_n = 0; ld_pend = 0;
        end
        svalid = 0; dvalid = 0; abs_addr = m_addr;
        if (pend_kind != 0) begin
            if (pend_cnt > 0) begin
                pend_cnt--;
            end else begin
                nb = (pend_kind == 1) ? 1 : 4;
                if (pend_kind == 1) begin svalid = 1; e_sack_n = 1; end
                else begin dvalid = 1; e_dack_n = 1; end
                if (resp_idx == fault_at) begin
                    abs_addr = m_addr + 2;
                    e_aerr_n = 1;
                end
                m_addr += AW'(nb);
                resp_idx++;
                e_left_n -= AW'(nb);
                if (e_left_n == 0) e_done_n = 1;
                pend_kind = 0;
            end
        end
        @(negedge clk);
        cyc++;
        checks++; if (bytes_left !== e_left) begin failures++; $display("FAIL bytes_left: got %0d expected %0d cyc %0d", bytes_left, e_left, cyc); end
        checks++; if (shift_ack !== e_sack) begin failures++; $display("FAIL shift_ack: got %b expected %b cyc %0d", shift_ack, e_sack, cyc); end
        checks++; if (data_ack !== e_dack) begin failures++; $display("FAIL data_ack: got %b expected %b cyc %0d", data_ack, e_dack, cyc); end
        checks++; if (blk_done !== e_done) begin failures++; $display("FAIL blk_done: got %b expected %b cyc %0d", blk_done, e_done, cyc); end
        checks++; if (addr_err !== e_aerr) begin failures++; $display("FAIL addr_err: got %b expected %b cyc %0d", addr_err, e_aerr, cyc); end
        checks++; if (rd_shift_en !== shift_gnt || rd_data_en !== data_gnt) begin
            failures++;
            $display("FAIL rd_en_vs_gnt: rd_shift_en %b shift_gnt %b rd_data_en %b data_gnt %b cyc %0d",
                     rd_shift_en, shift_gnt, rd_data_en, data_gnt, cyc);
        end
        if (busy) begin
            checks++;
            if (rd_shift_en || rd_data_en) begin failures++; $display("FAIL busy_issue: command issued while busy cyc %0d", cyc); end
        end
        if (blk_done === 1'b1) done_cnt++;
        if (shift_gnt === 1'b1 || data_gnt === 1'b1) begin
            k = (shift_gnt === 1'b1) ? 1 : 2;
            n_gnt++;
            if (k == 1) n_sgnt++; else n_dgnt++;
            checks++;
            if (shift_gnt === 1'b1 && data_gnt === 1'b1) begin
                failures++; $display("FAIL grant_onehot: both grants high cyc %0d", cyc);
            end else if (exp_q.size() == 0) begin
                failures++; $display("FAIL grant_order: got grant %0d expected none cyc %0d", k, cyc);
            end else begin
                ek = exp_q.pop_front();
                if (k != ek) begin failures++; $display("FAIL grant_order: got %0d expected %0d cyc %0d", k, ek, cyc); end
            end
            if (resp_en) begin pend_kind = k; pend_cnt = resp_dly - 1; end
        end
    endtask

    task automatic start_block(input int len);
        n_len = AW'(len); n_start = 1; ld_pend = 1; ld_val = AW'(len);
        step();
        n_start = 0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int i;
        d0 = done_cnt; i = 0;
        while (done_cnt == d0 && i < budget) begin step(); i++; end
        checks++;
        if (done_cnt == d0) begin failures++; $display("FAIL wait_done: blk_done got 0 pulses expected 1 within %0d cycles", budget); end
    endtask

    task automatic wait_grant(input int budget);
        int g0;
        int i;
        g0 = n_gnt; i = 0;
        while (n_gnt == g0 && i < budget) begin step(); i++; end
        checks++;
        if (n_gnt == g0) begin failures++; $display("FAIL wait_grant: got no grant expected one within %0d cycles", budget); end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; blk_start = 0; shift_req = 0; data_req = 0; busy = 0; svalid = 0; dvalid = 0;
        n_start = 0; n_sreq = 0; n_dreq = 0; n_busy = 0;
        @(posedge clk); #1;
        clear_model();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({shift_gnt, shift_ack, data_gnt, data_ack, rd_shift_en, rd_data_en, blk_done, timeout_err, addr_err} !== 9'b0 || bytes_left !== '0) begin
            failures++; $display("FAIL reset_state: outputs not all zero, bytes_left %0d", bytes_left);
        end
        n_sreq = 1; n_dreq = 1;
        repeat (3) step();
        checks++; if (n_gnt != 0) begin failures++; $display("FAIL idle_no_grant: got %0d grants expected 0", n_gnt); end
    endtask

    task automatic test_shift_only();
        do_reset();
        m_addr = 32'h1000; resp_dly = 2; n_sreq = 1;
        plan(8, 1, 0);
        start_block(8);
        wait_done(100);
        repeat (3) step();
        checks++; if (n_sgnt != 8) begin failures++; $display("FAIL shift_only_count: got %0d expected 8", n_sgnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL shift_only_left: got %0d pending expected 0", exp_q.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL shift_only_done: got %0d expected 1", done_cnt); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL shift_only_tmo: got %b expected 0", timeout_err); end
        n_sreq = 0;
    endtask

    task automatic test_mixed();
        do_reset();
        m_addr = 32'h0; resp_dly = 1; n_sreq = 1; n_dreq = 1;
        plan(16, 1, 1);
        start_block(16);
        wait_done(100);
        // starve count stays at max across DONE, so the next block opens with a shift
        plan(23, 1, 1);
        start_block(23);
        wait_done(150);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mixed_left: got %0d pending expected 0", exp_q.size()); end
        checks++; if (n_dgnt != 9) begin failures++; $display("FAIL mixed_data_cnt: got %0d expected 9", n_dgnt); end
        checks++; if (n_sgnt != 3) begin failures++; $display("FAIL mixed_shift_cnt: got %0d expected 3", n_sgnt); end
        n_sreq = 0; n_dreq = 0;
    endtask

    task automatic test_data_holdoff();
        do_reset();
        m_addr = 32'h40; resp_dly = 1; n_dreq = 1;
        plan(6, 0, 1);
        start_block(6);
        repeat (12) step();
        checks++; if (bytes_left !== 32'd2) begin failures++; $display("FAIL holdoff_left: got %0d expected 2", bytes_left); end
        checks++; if (n_dgnt != 1) begin failures++; $display("FAIL holdoff_dgnt: got %0d expected 1", n_dgnt); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL holdoff_done: got %0d expected 0", done_cnt); end
        n_sreq = 1;
        plan(0, 1, 1);
        wait_done(40);
        checks++; if (n_sgnt != 2) begin failures++; $display("FAIL holdoff_sgnt: got %0d expected 2", n_sgnt); end
        n_sreq = 0; n_dreq = 0;
    endtask

    task automatic test_busy();
        do_reset();
        m_addr = 32'h80; resp_dly = 1; n_busy = 1; n_sreq = 1;
        plan(2, 1, 0);
        start_block(2);
        repeat (10) step();
        checks++; if (n_gnt != 0) begin failures++; $display("FAIL busy_hold: got %0d grants expected 0", n_gnt); end
        n_busy = 0;
        step();
        checks++; if (n_gnt != 1) begin failures++; $display("FAIL busy_release: got %0d grants expected 1", n_gnt); end
        wait_done(30);
        n_sreq = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        m_addr = 32'h300; resp_en = 0; n_sreq = 1;
        plan(1, 1, 0);
        start_block(1);
        wait_grant(10);
        for (int k = 1; k <= TMO; k++) begin
            step();
            if (k == TMO - 1) begin
                checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_early: got %b expected 0 at %0d", timeout_err, k); end
            end
            if (k == TMO) begin
                checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_expire: got %b expected 1 at %0d", timeout_err, k); end
            end
        end
        repeat (5) step();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky: got %b expected 1", timeout_err); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL tmo_no_done: got %0d expected 0", done_cnt); end
        resp_en = 1; resp_dly = 1;
        plan(1, 1, 0);
        start_block(1);
        step();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear: got %b expected 0", timeout_err); end
        wait_done(20);
        n_sreq = 0;
    endtask

    task automatic test_addr_err_and_rst();
        do_reset();
        m_addr = 32'h200; resp_dly = 1; fault_at = 2; n_sreq = 1;
        plan(5, 1, 0);
        start_block(5);
        wait_done(60);
        checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL addr_err_final: got %b expected 1", addr_err); end
        resp_dly = 3;
        plan(4, 1, 0);
        start_block(4);
        wait_grant(5);
        checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL addr_err_clear: got %b expected 0", addr_err); end
        // reset lands while the shift is outstanding
        @(posedge clk); #1;
        rst = 1; shift_req = 0; n_sreq = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({shift_gnt, shift_ack, data_gnt, data_ack, rd_shift_en, rd_data_en, blk_done, timeout_err, addr_err} !== 9'b0 || bytes_left !== '0) begin
            failures++; $display("FAIL rst_mid_wait: outputs not all zero, bytes_left %0d", bytes_left);
        end
        clear_model();
        rst = 0;
        @(posedge clk); #1; svalid = 1;
        @(posedge clk); #1; svalid = 0;
        @(negedge clk);
        checks++;
        if (shift_ack !== 1'b0 || bytes_left !== '0 || blk_done !== 1'b0) begin
            failures++; $display("FAIL late_svalid: ack %b left %0d done %b expected 0 0 0", shift_ack, bytes_left, blk_done);
        end
        repeat (2) step();
    endtask

    initial begin
        rst = 1; blk_start = 0; shift_req = 0; data_req = 0; busy = 0;
        svalid = 0; dvalid = 0; blk_len = '0; abs_addr = '0;
        n_start = 0; n_sreq = 0; n_dreq = 0; n_busy = 0; n_len = '0;
        m_addr = '0;
        clear_model();
        test_reset();
        test_shift_only();
        test_mixed();
        test_data_holdoff();
        test_busy();
        test_timeout();
        test_addr_err_and_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte4_sched.md
Name: byte4_sched

Overview:
- Sequencer/arbiter in front of byte_addressing in the LZ4 compress path.
- Two requesters share the single byte4 read port:
  - match finder: shift request, advances the window 1 byte and returns byte4_shift on byte4_svalid.
  - literal copier: data request, consumes 4 bytes and returns data on byte4_dvalid.
- Issues rd_shift_en / rd_data_en pulses, holds one command outstanding, and counts bytes per compression block.
- Flags end-of-block and response timeouts.

Parameters:
- ADDR_W, 32, width of block length, byte counter and abs_addr.
- STARVE_MAX, 4, consecutive shift losses before shift gets forced priority.
- TMO_CYC, 64, cycles allowed from issue to response before timeout_err.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- blk_start  in  1  pulse; latch blk_len, begin a block (ignored unless IDLE/DONE).
- blk_len  in  ADDR_W  block length in bytes, must be >=1.
- shift_req  in  1  match finder wants a 1-byte shift (level, held until shift_gnt).
- shift_gnt  out  1  1-cycle grant pulse to match finder.
- shift_ack  out  1  registered copy of byte4_svalid while the shift command is outstanding.
- data_req  in  1  literal copier wants 4 bytes (level, held until data_gnt).
- data_gnt  out  1  1-cycle grant pulse to literal copier.
- data_ack  out  1  registered copy of byte4_dvalid while the data command is outstanding.
- rd_shift_en  out  1  to byte_addressing, 1-cycle pulse.
- rd_data_en  out  1  to byte_addressing, 1-cycle pulse.
- byte4_busy  in  1  byte_addressing cannot accept a command.
- byte4_svalid  in  1  shift response valid.
- byte4_dvalid  in  1  data response valid.
- abs_addr  in  ADDR_W  byte_addressing absolute byte address (checked only).
- bytes_left  out  ADDR_W  bytes remaining in the current block.
- blk_done  out  1  1-cycle pulse when bytes_left reaches 0 and the last response returns.
- timeout_err  out  1  sticky until rst or blk_start.
- addr_err  out  1  sticky; abs_addr mismatched expected address at a response.

Behaviour:
- Reset: all outputs 0, bytes_left 0, state IDLE, starve counter 0, timeout counter 0.
- Response rule: byte4_svalid/byte4_dvalid outside a matching outstanding command are ignored.
- IDLE:
  - blk_start -> RUN.
  - bytes_left <= blk_len; exp_addr <= abs_addr sampled that cycle.
  - timeout_err and addr_err cleared.
- RUN, issue condition: no command outstanding, !byte4_busy, bytes_left>0.
- RUN, arbitration:
  - data wins by default.
  - Shift wins if starve_cnt == STARVE_MAX or data_req=0.
  - Data is eligible only if bytes_left>=4; otherwise data_req is held off until the block ends.
- RUN, on issue:
  - rd_*_en and *_gnt pulse in the same cycle.
  - Command type is recorded.
  - State -> WAIT.
- Starve counter:
  - Increments (saturating) when shift_req loses to data.
  - Clears on shift grant or when shift_req=0.
- WAIT:
  - Timeout counter counts from 1.
  - On the matching valid: *_ack=1 the next cycle (1-cycle registered latency).
  - Shift response: bytes_left -=1, exp_addr +=1. Data response: bytes_left -=4, exp_addr +=4.
  - abs_addr is compared to exp_addr before the update; mismatch sets addr_err.
  - After the response: bytes_left==0 -> DONE with blk_done pulse; else -> RUN.
  - Timeout counter reaching TMO_CYC: timeout_err=1, state -> DONE, no blk_done.
- DONE:
  - No grants.
  - blk_start -> reload as in IDLE, then RUN.
- Simultaneous events:
  - blk_start during RUN/WAIT is ignored.
  - Both requests with STARVE_MAX reached -> shift.
  - Response in the same cycle as timeout expiry -> response wins, no error.
- Reset mid-block: all state is dropped immediately next edge; the outstanding response is discarded.
- Arithmetic: unsigned; bytes_left never wraps below 0 (guaranteed by the data-eligibility rule).

Decomposition:
- Package byte4_sched_pkg:
  - State encoding IDLE/RUN/WAIT/DONE.
  - Command type enum NONE/SHIFT/DATA.
  - Byte increments SHIFT_BYTES=1, DATA_BYTES=4.
- Sub-module byte4_arb: 2-way starvation-limited priority arbiter (combinational grant plus starve counter register).
- Counters and FSM stay in the top level.

Test Plan:
- Reset then blk_start, blk_len=8, only shift_req high, svalid 2 cycles after each issue -> 8 shift_gnt pulses, bytes_left 8->0, single blk_done, no errors.
- blk_len=16, data_req and shift_req both constantly high, STARVE_MAX=4 -> grant pattern D,D,D,D,S repeats until bytes_left<4, then only S; blk_done when bytes_left=0.
- blk_len=6, only data_req -> one data grant (left 2), then data held off; add shift_req -> 2 shifts, blk_done.
- byte4_busy held high 10 cycles in RUN -> no rd_*_en pulses; first issue the cycle after busy drops.
- Issue shift, never return svalid, TMO_CYC=64 -> timeout_err=1 at cycle 64 after issue, state DONE, no blk_done; blk_start clears it.
- abs_addr returned as exp+2 on the 3rd response -> addr_err sticks at 1; rst asserted mid-WAIT -> all outputs 0 next cycle and a late svalid is ignored.
